// File: rtl/uart_tx_8n1_if.sv
// uart_tx_8n1_if: word handshake between a byte producer and the UART transmitter.
//   tx_valid : producer -> transmitter, a word is present on tx_data
//   tx_data  : producer -> transmitter, 8-bit word, sampled only on the accept edge
//   tx_ready : transmitter -> producer, a word can be accepted this cycle
// master = producer side, slave = transmitter side.
interface uart_tx_8n1_if;
  logic       tx_valid;
  logic [7:0] tx_data;
  logic       tx_ready;

  modport master (
    output tx_valid,
    output tx_data,
    input  tx_ready
  );

  modport slave (
    input  tx_valid,
    input  tx_data,
    output tx_ready
  );
endinterface

// File: rtl/uart_tx_8n1.sv
// uart_tx_8n1: UART transmitter, 1 start bit, 8 data bits LSB-first,
// optional parity bit, 1 stop bit. Bit time is CLKS_PER_BIT clock cycles.
//   clk   : system clock, rising edge
//   rst   : synchronous reset, active-high
//   s_if  : slave side of the tx_valid/tx_data/tx_ready handshake
//   tx    : serial line, idle high, registered
//   busy  : a frame is in progress (state != IDLE)
module uart_tx_8n1 #(
  parameter int unsigned CLKS_PER_BIT = 16,
  parameter bit          PARITY_EN    = 1'b0,
  parameter bit          PARITY_ODD   = 1'b0
) (
  input  logic           clk,
  input  logic           rst,
  uart_tx_8n1_if.slave   s_if,
  output logic           tx,
  output logic           busy
);

  localparam int unsigned CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CW-1:0] LAST_CNT = CW'(CLKS_PER_BIT - 1);

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP
  } state_t;

  state_t        r_state;
  logic [CW-1:0] r_cnt;
  logic [2:0]    r_bit_idx;
  logic [7:0]    r_shift;
  logic          r_parity;
  logic          r_tx;

  state_t        w_state_nxt;
  logic [CW-1:0] w_cnt_nxt;
  logic [2:0]    w_bit_idx_nxt;
  logic [7:0]    w_shift_nxt;
  logic          w_parity_nxt;
  logic          w_tx_nxt;
  logic          w_bit_end;
  logic          w_ready;
  logic          w_accept;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= IDLE;
      r_cnt     <= '0;
      r_bit_idx <= '0;
      r_shift   <= '0;
      r_parity  <= 1'b0;
      r_tx      <= 1'b1;
    end else begin
      r_state   <= w_state_nxt;
      r_cnt     <= w_cnt_nxt;
      r_bit_idx <= w_bit_idx_nxt;
      r_shift   <= w_shift_nxt;
      r_parity  <= w_parity_nxt;
      r_tx      <= w_tx_nxt;
    end
  end

  always_comb begin
    w_bit_end = (r_cnt == LAST_CNT);
    // Ready also in the final STOP cycle so a following word starts with no idle gap.
    w_ready   = (r_state == IDLE) || ((r_state == STOP) && w_bit_end);
    w_accept  = s_if.tx_valid && w_ready;

    w_state_nxt   = r_state;
    w_cnt_nxt     = r_cnt + CW'(1);
    w_bit_idx_nxt = r_bit_idx;
    w_shift_nxt   = r_shift;
    w_parity_nxt  = r_parity;

    unique case (r_state)
      IDLE: begin
        w_cnt_nxt = '0;
        if (w_accept) begin
          w_state_nxt   = START;
          w_bit_idx_nxt = '0;
          w_shift_nxt   = s_if.tx_data;
          w_parity_nxt  = (^s_if.tx_data) ^ PARITY_ODD;
        end
      end
      START: begin
        if (w_bit_end) begin
          w_state_nxt   = DATA;
          w_cnt_nxt     = '0;
          w_bit_idx_nxt = '0;
        end
      end
      DATA: begin
        if (w_bit_end) begin
          w_cnt_nxt   = '0;
          w_shift_nxt = {1'b0, r_shift[7:1]};
          if (r_bit_idx == 3'd7) begin
            w_state_nxt = PARITY_EN ? PARITY : STOP;
          end else begin
            w_bit_idx_nxt = r_bit_idx + 3'd1;
          end
        end
      end
      PARITY: begin
        if (w_bit_end) begin
          w_state_nxt = STOP;
          w_cnt_nxt   = '0;
        end
      end
      STOP: begin
        if (w_bit_end) begin
          w_cnt_nxt = '0;
          if (w_accept) begin
            w_state_nxt   = START;
            w_bit_idx_nxt = '0;
            w_shift_nxt   = s_if.tx_data;
            w_parity_nxt  = (^s_if.tx_data) ^ PARITY_ODD;
          end else begin
            w_state_nxt = IDLE;
          end
        end
      end
      default: begin
        w_state_nxt = IDLE;
        w_cnt_nxt   = '0;
      end
    endcase

    // tx is registered: drive the level belonging to the state being entered,
    // so the line changes on the same edge as the state.
    w_tx_nxt = 1'b1;
    unique case (w_state_nxt)
      START:   w_tx_nxt = 1'b0;
      DATA:    w_tx_nxt = w_shift_nxt[0];
      PARITY:  w_tx_nxt = w_parity_nxt;
      default: w_tx_nxt = 1'b1;
    endcase
  end

  assign s_if.tx_ready = w_ready;
  assign tx            = r_tx;
  assign busy          = (r_state != IDLE);

endmodule

// File: tb/tb_uart_tx_8n1.sv
module tb_uart_tx_8n1;
  localparam int CPB = 4;

  logic clk;
  logic rst;
  logic tx0, tx1, tx2;
  logic busy0, busy1, busy2;
  int   checks;
  int   errors;

  uart_tx_8n1_if if0 ();
  uart_tx_8n1_if if1 ();
  uart_tx_8n1_if if2 ();

  uart_tx_8n1 #(.CLKS_PER_BIT(CPB), .PARITY_EN(1'b0), .PARITY_ODD(1'b0)) dut (
    .clk(clk), .rst(rst), .s_if(if0.slave), .tx(tx0), .busy(busy0));
  uart_tx_8n1 #(.CLKS_PER_BIT(CPB), .PARITY_EN(1'b1), .PARITY_ODD(1'b0)) dut_pe (
    .clk(clk), .rst(rst), .s_if(if1.slave), .tx(tx1), .busy(busy1));
  uart_tx_8n1 #(.CLKS_PER_BIT(CPB), .PARITY_EN(1'b1), .PARITY_ODD(1'b1)) dut_po (
    .clk(clk), .rst(rst), .s_if(if2.slave), .tx(tx2), .busy(busy2));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference: expected line level at cycle i after the accept edge.
  function automatic logic exp_tx(input logic [7:0] d, input bit pen, input bit podd, input int i);
    int b;
    b = i / CPB;
    if (b == 0) return 1'b0;
    if (b <= 8) return d[b-1];
    if (pen && b == 9) return (^d) ^ podd;
    return 1'b1;
  endfunction

  task automatic drive(input int which, input logic v, input logic [7:0] d);
    case (which)
      0: begin if0.tx_valid = v; if0.tx_data = d; end
      1: begin if1.tx_valid = v; if1.tx_data = d; end
      default: begin if2.tx_valid = v; if2.tx_data = d; end
    endcase
  endtask

  task automatic sample(input int which, output logic t, output logic r, output logic b);
    case (which)
      0: begin t = tx0; r = if0.tx_ready; b = busy0; end
      1: begin t = tx1; r = if1.tx_ready; b = busy1; end
      default: begin t = tx2; r = if2.tx_ready; b = busy2; end
    endcase
  endtask

  task automatic test_reset();
    logic t, r, b;
    rst = 1'b1;
    for (int w = 0; w < 3; w++) drive(w, 1'b1, 8'($urandom));
    for (int c = 0; c < 2; c++) begin
      @(negedge clk);
      for (int w = 0; w < 3; w++) begin
        sample(w, t, r, b);
        checks++;
        if (t !== 1'b1 || r !== 1'b1 || b !== 1'b0) begin
          errors++;
          $display("FAIL reset dut%0d cyc%0d: tx=%b ready=%b busy=%b, want 1 1 0", w, c, t, r, b);
        end
      end
    end
    for (int w = 0; w < 3; w++) drive(w, 1'b0, 8'h00);
    rst = 1'b0;
    @(negedge clk);
    for (int w = 0; w < 3; w++) begin
      sample(w, t, r, b);
      checks++;
      if (t !== 1'b1 || r !== 1'b1 || b !== 1'b0) begin
        errors++;
        $display("FAIL reset_release dut%0d: tx=%b ready=%b busy=%b, want 1 1 0", w, t, r, b);
      end
    end
  endtask

  task automatic test_single_frame();
    logic t, r, b;
    logic [7:0] d;
    for (int k = 0; k < 4; k++) begin
      d = (k == 0) ? 8'hA5 : 8'($urandom);
      drive(0, 1'b1, d);
      @(negedge clk);
      drive(0, 1'b0, 8'($urandom));
      for (int i = 0; i < 10*CPB; i++) begin
        sample(0, t, r, b);
        checks++;
        if (t !== exp_tx(d, 0, 0, i) || r !== (i == 10*CPB-1) || b !== 1'b1) begin
          errors++;
          $display("FAIL single d=%h i=%0d: tx=%b ready=%b busy=%b, want %b %b 1",
                   d, i, t, r, b, exp_tx(d, 0, 0, i), (i == 10*CPB-1));
        end
        @(negedge clk);
      end
      sample(0, t, r, b);
      checks++;
      if (t !== 1'b1 || r !== 1'b1 || b !== 1'b0) begin
        errors++;
        $display("FAIL single_end d=%h: tx=%b ready=%b busy=%b, want 1 1 0", d, t, r, b);
      end
    end
  endtask

  task automatic test_back_to_back();
    logic t, r, b, e;
    drive(0, 1'b1, 8'h00);
    @(negedge clk);
    drive(0, 1'b1, 8'hFF);
    for (int i = 0; i < 20*CPB; i++) begin
      sample(0, t, r, b);
      e = (i < 10*CPB) ? exp_tx(8'h00, 0, 0, i) : exp_tx(8'hFF, 0, 0, i - 10*CPB);
      checks++;
      if (t !== e || r !== (i == 10*CPB-1 || i == 20*CPB-1) || b !== 1'b1) begin
        errors++;
        $display("FAIL b2b i=%0d: tx=%b ready=%b busy=%b, want %b %b 1",
                 i, t, r, b, e, (i == 10*CPB-1 || i == 20*CPB-1));
      end
      if (i == 10*CPB) drive(0, 1'b0, 8'h00);
      @(negedge clk);
    end
    sample(0, t, r, b);
    checks++;
    if (t !== 1'b1 || r !== 1'b1 || b !== 1'b0) begin
      errors++;
      $display("FAIL b2b_end: tx=%b ready=%b busy=%b, want 1 1 0", t, r, b);
    end
  endtask

  task automatic test_parity();
    logic t, r, b;
    logic [7:0] d;
    bit podd;
    for (int w = 1; w < 3; w++) begin
      podd = (w == 2);
      for (int k = 0; k < 3; k++) begin
        d = (k == 0) ? 8'h07 : 8'($urandom);
        drive(w, 1'b1, d);
        @(negedge clk);
        drive(w, 1'b0, 8'($urandom));
        for (int i = 0; i < 11*CPB; i++) begin
          sample(w, t, r, b);
          checks++;
          if (t !== exp_tx(d, 1, podd, i) || r !== (i == 11*CPB-1) || b !== 1'b1) begin
            errors++;
            $display("FAIL parity odd=%0d d=%h i=%0d: tx=%b ready=%b busy=%b, want %b %b 1",
                     podd, d, i, t, r, b, exp_tx(d, 1, podd, i), (i == 11*CPB-1));
          end
          if (k == 0 && i == 9*CPB) begin
            checks++;
            if (t !== (podd ? 1'b0 : 1'b1)) begin
              errors++;
              $display("FAIL parity_07 odd=%0d: parity bit=%b, want %b", podd, t, !podd);
            end
          end
          @(negedge clk);
        end
        sample(w, t, r, b);
        checks++;
        if (t !== 1'b1 || r !== 1'b1 || b !== 1'b0) begin
          errors++;
          $display("FAIL parity_end odd=%0d: tx=%b ready=%b busy=%b, want 1 1 0", podd, t, r, b);
        end
      end
    end
  endtask

  task automatic test_mid_reset();
    logic t, r, b;
    drive(0, 1'b1, 8'h3C);
    @(negedge clk);
    drive(0, 1'b0, 8'h00);
    for (int i = 0; i <= 4*CPB + 1; i++) begin
      sample(0, t, r, b);
      checks++;
      if (t !== exp_tx(8'h3C, 0, 0, i) || b !== 1'b1) begin
        errors++;
        $display("FAIL midrst_pre i=%0d: tx=%b busy=%b, want %b 1", i, t, b, exp_tx(8'h3C, 0, 0, i));
      end
      if (i < 4*CPB + 1) @(negedge clk);
    end
    rst = 1'b1;
    @(negedge clk);
    sample(0, t, r, b);
    checks++;
    if (t !== 1'b1 || r !== 1'b1 || b !== 1'b0) begin
      errors++;
      $display("FAIL midrst_abort: tx=%b ready=%b busy=%b, want 1 1 0", t, r, b);
    end
    rst = 1'b0;
    drive(0, 1'b1, 8'h81);
    @(negedge clk);
    drive(0, 1'b0, 8'h00);
    for (int i = 0; i < 10*CPB; i++) begin
      sample(0, t, r, b);
      checks++;
      if (t !== exp_tx(8'h81, 0, 0, i) || r !== (i == 10*CPB-1) || b !== 1'b1) begin
        errors++;
        $display("FAIL midrst_post i=%0d: tx=%b ready=%b busy=%b, want %b %b 1",
                 i, t, r, b, exp_tx(8'h81, 0, 0, i), (i == 10*CPB-1));
      end
      @(negedge clk);
    end
  endtask

  task automatic test_data_stability();
    logic t, r, b;
    logic [7:0] dec;
    dec = 8'h00;
    drive(0, 1'b1, 8'h5A);
    @(negedge clk);
    for (int i = 0; i < 10*CPB; i++) begin
      drive(0, 1'b0, 8'($urandom));
      sample(0, t, r, b);
      checks++;
      if (t !== exp_tx(8'h5A, 0, 0, i)) begin
        errors++;
        $display("FAIL stable i=%0d: tx=%b, want %b", i, t, exp_tx(8'h5A, 0, 0, i));
      end
      if ((i % CPB) == CPB/2 && i / CPB >= 1 && i / CPB <= 8) dec[i/CPB - 1] = t;
      @(negedge clk);
    end
    checks++;
    if (dec !== 8'h5A) begin
      errors++;
      $display("FAIL stable_decode: got %h, want 5a", dec);
    end
  endtask

  // 256 words from a free-running byte counter, valid held high, decoded by a
  // mid-bit sampling receiver that watches only the serial line.
  task automatic test_loopback();
    logic t, r, b;
    logic [7:0] q[$];
    logic [7:0] cnt_val, rx_byte, want;
    bit   acc_pend, rx_active;
    int   sent, frames, ferr, rx_cnt, k, cyc;
    cnt_val = 8'h00; sent = 0; frames = 0; ferr = 0; rx_active = 0; rx_cnt = 0;
    rx_byte = 8'h00; cyc = 0;
    drive(0, 1'b1, cnt_val);
    acc_pend = 1'b1;
    q.push_back(cnt_val);
    while (frames < 256 && cyc < 256*10*CPB + 200) begin
      @(negedge clk);
      cyc++;
      if (acc_pend) begin
        sent++;
        cnt_val = cnt_val + 8'd1;
        if (sent == 256) drive(0, 1'b0, cnt_val);
        else drive(0, 1'b1, cnt_val);
      end
      sample(0, t, r, b);
      acc_pend = r && if0.tx_valid;
      if (acc_pend) q.push_back(cnt_val);
      if (!rx_active) begin
        if (t == 1'b0) begin
          rx_active = 1;
          rx_cnt = 0;
        end
      end else begin
        rx_cnt++;
      end
      if (rx_active && (rx_cnt % CPB) == CPB/2) begin
        k = rx_cnt / CPB;
        if (k == 0 && t !== 1'b0) begin
          ferr++;
          rx_active = 0;
        end else if (k >= 1 && k <= 8) begin
          rx_byte[k-1] = t;
        end else if (k == 9) begin
          rx_active = 0;
          frames++;
          if (t !== 1'b1) ferr++;
          want = (q.size() > 0) ? q.pop_front() : 8'hxx;
          checks++;
          if (rx_byte !== want) begin
            errors++;
            $display("FAIL loopback frame %0d: got %h, want %h", frames, rx_byte, want);
          end
        end
      end
    end
    checks++;
    if (frames != 256 || ferr != 0) begin
      errors++;
      $display("FAIL loopback_summary: frames=%0d framing_errors=%0d, want 256 0", frames, ferr);
    end
    repeat (2*CPB) @(negedge clk);
  endtask

  initial begin
    checks = 0;
    errors = 0;
    rst = 1'b1;
    for (int w = 0; w < 3; w++) drive(w, 1'b0, 8'h00);
    test_reset();
    test_single_frame();
    test_back_to_back();
    test_parity();
    test_mid_reset();
    test_data_stability();
    test_loopback();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
